// File: rtl/accu_store_unit.sv
// rtl/accu_store_unit.sv - accumulator snapshot store engine with req/ack memory write
//
// Takes a snapshot of the accumulator on store_req and writes it to data memory
// through a request/acknowledge handshake. The control unit can move on as soon
// as the request is accepted and only has to wait for !store_busy before the next one.
//
// Ports:
//   clk, rst (async, active-low), ce (clock enable, freezes everything when 0)
//   store_req / store_addr / ACCU_IN : store command from the control unit
//   mem_ack                          : memory accepted the write
//   mem_addr / mem_wdata / mem_we    : registered memory write port
//   store_busy / store_done          : status back to the control unit
//   err_timeout                      : sticky flag, last store ended without ack

module accu_store_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] ACCU_IN,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              store_busy,
    output logic              store_done,
    output logic              err_timeout
);

    // TIMEOUT=0 disables the timeout; keep a 1-bit counter so the width stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              we_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            store_busy  <= 1'b0;
            store_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else if (ce) begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            mem_we      <= we_nxt;
            store_busy  <= busy_nxt;
            store_done  <= done_nxt;
            err_timeout <= err_nxt;
        end
    end

    // Outputs are computed as the value they must hold in the *next* state,
    // so every output is a plain register with no path from the inputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        we_nxt    = 1'b0;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        err_nxt   = err_timeout;

        unique case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (store_req) begin
                    state_nxt = ST_SETUP;
                    addr_nxt  = store_addr;
                    wdata_nxt = ACCU_IN;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                // One cycle of address/data setup before the strobe rises.
                state_nxt = ST_WRITE;
                we_nxt    = 1'b1;
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    we_nxt  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                // A request seen here is dropped; the caller retries once busy falls.
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_accu_store_unit.sv
// tb/tb_accu_store_unit.sv - directed self-checking bench for accu_store_unit

module tb_accu_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        store_req = 1'b0;
    logic [5:0]  store_addr = '0;
    logic [15:0] ACCU_IN = '0;
    logic        mem_ack = 1'b0;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        store_busy;
    logic        store_done;
    logic        err_timeout;

    int n_err = 0;
    int n_chk = 0;
    int we_cnt;

    accu_store_unit #(.DATA_W(16), .ADDR_W(6), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .store_req(store_req), .store_addr(store_addr), .ACCU_IN(ACCU_IN),
        .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .store_busy(store_busy), .store_done(store_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mem_we each cycle until it falls; caller has already seen one high cycle.
    task automatic count_we(inout int cnt);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mem_we) cnt++;
            else return;
        end
        chk("we_bound", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_we", mem_we, 1'b0);
        chk("rst_busy", store_busy, 1'b0);
        chk("rst_addr", mem_addr, 6'h00);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_err", err_timeout, 1'b0);
        #20 rst = 1'b1;
        tick();

        // Zero-wait store
        store_req = 1'b1; store_addr = 6'h2A; ACCU_IN = 16'hBEEF; mem_ack = 1'b1;
        tick();                                   // E0
        store_req = 1'b0;
        chk("zw_e0_busy", store_busy, 1'b1);
        chk("zw_e0_we", mem_we, 1'b0);
        chk("zw_e0_addr", mem_addr, 6'h2A);
        chk("zw_e0_wdata", mem_wdata, 16'hBEEF);
        tick();                                   // E1
        chk("zw_e1_we", mem_we, 1'b1);
        chk("zw_e1_done", store_done, 1'b0);
        tick();                                   // E2
        chk("zw_e2_we", mem_we, 1'b0);
        chk("zw_e2_done", store_done, 1'b1);
        chk("zw_e2_err", err_timeout, 1'b0);
        tick();                                   // E3
        chk("zw_e3_done", store_done, 1'b0);
        chk("zw_e3_busy", store_busy, 1'b0);

        // Wait states plus snapshot
        mem_ack = 1'b0; store_req = 1'b1; store_addr = 6'h05; ACCU_IN = 16'hBEEF;
        tick();
        store_req = 1'b0; ACCU_IN = 16'h1234;
        tick();
        chk("ws_we_first", mem_we, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ws_we_hold", mem_we, 1'b1);
        end
        chk("ws_wdata", mem_wdata, 16'hBEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ws_we_off", mem_we, 1'b0);
        chk("ws_done", store_done, 1'b1);
        chk("ws_err", err_timeout, 1'b0);
        tick();
        chk("ws_done_pulse", store_done, 1'b0);

        // Timeout: ack never comes
        store_req = 1'b1; store_addr = 6'h11; ACCU_IN = 16'h5A5A;
        tick();
        store_req = 1'b0;
        tick();
        we_cnt = mem_we ? 1 : 0;
        count_we(we_cnt);
        chk("to_we_cycles", we_cnt, 15);
        chk("to_done", store_done, 1'b1);
        chk("to_err", err_timeout, 1'b1);
        tick();
        tick();
        tick();
        chk("to_err_sticky", err_timeout, 1'b1);
        chk("to_idle", store_busy, 1'b0);

        // ce gating in WRITE and DONE
        store_req = 1'b1; store_addr = 6'h22;
        tick();
        store_req = 1'b0;
        chk("ce_err_clr", err_timeout, 1'b0);
        tick();
        we_cnt = mem_we ? 1 : 0;
        tick(); if (mem_we) we_cnt++;
        tick(); if (mem_we) we_cnt++;
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we) we_cnt++;
        end
        chk("ce_we_frozen", mem_we, 1'b1);
        ce = 1'b1;
        count_we(we_cnt);
        chk("ce_we_cycles", we_cnt, 18);
        chk("ce_done", store_done, 1'b1);
        chk("ce_err", err_timeout, 1'b1);
        ce = 1'b0;
        tick(); tick(); tick();
        chk("ce_done_stretch", store_done, 1'b1);
        ce = 1'b1;
        tick();
        chk("ce_done_end", store_done, 1'b0);

        // Overlapping requests
        store_req = 1'b1; store_addr = 6'h0C; ACCU_IN = 16'h0C0C;
        tick();                                   // SETUP
        store_addr = 6'h3F; ACCU_IN = 16'hAAAA;
        tick();                                   // WRITE
        chk("ov_we", mem_we, 1'b1);
        tick();
        mem_ack = 1'b1;
        tick();                                   // DONE
        mem_ack = 1'b0;
        chk("ov_done", store_done, 1'b1);
        chk("ov_addr_hold", mem_addr, 6'h0C);
        tick();                                   // IDLE, req in DONE ignored
        chk("ov_idle_busy", store_busy, 1'b0);
        chk("ov_idle_we", mem_we, 1'b0);
        chk("ov_wdata_hold", mem_wdata, 16'h0C0C);
        tick();                                   // req accepted in first IDLE cycle
        store_req = 1'b0;
        chk("ov_accept_busy", store_busy, 1'b1);
        chk("ov_accept_addr", mem_addr, 6'h3F);
        chk("ov_accept_wdata", mem_wdata, 16'hAAAA);

        // Async reset mid-WRITE
        tick();
        chk("ar_we_pre", mem_we, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("ar_we", mem_we, 1'b0);
        chk("ar_busy", store_busy, 1'b0);
        chk("ar_addr", mem_addr, 6'h00);
        chk("ar_wdata", mem_wdata, 16'h0000);
        #2 rst = 1'b1;
        tick();
        tick();
        chk("ar_idle", store_busy, 1'b0);
        chk("ar_idle_we", mem_we, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
